// File: rtl/pwm_meter.sv
// PWM period / high-time meter: synchronises an asynchronous PWM stream and
// reports high and period lengths in clk cycles through a valid/ready register.
module pwm_meter #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             overflow,
   output logic             dropped
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RISE,
      MEAS_HIGH,
      MEAS_LOW
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   s_pwm;
   logic                   s_prev;
   logic                   rise;
   logic                   fall;
   logic [CNT_W-1:0]       pc;
   logic [CNT_W-1:0]       hc;
   logic                   pc_sat;
   logic                   done;

   always_comb begin
      s_pwm  = sync[SYNC_STAGES-1];
      rise   = s_pwm & ~s_prev;
      fall   = ~s_pwm & s_prev;
      pc_sat = (pc == CNT_MAX);
      // A closing rise only counts if the period counter has not saturated.
      done   = en && (state == MEAS_LOW) && rise && !pc_sat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync   <= '0;
         s_prev <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], pwm_in};
         s_prev <= s_pwm;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= '0;
         hc         <= '0;
         high_cnt   <= '0;
         period_cnt <= '0;
         meas_valid <= 1'b0;
         overflow   <= 1'b0;
         dropped    <= 1'b0;
      end else begin
         if (clear) begin
            overflow <= 1'b0;
            dropped  <= 1'b0;
         end

         if (!en) begin
            state <= IDLE;
            pc    <= '0;
            hc    <= '0;
         end else begin
            case (state)
               IDLE: state <= WAIT_RISE;
               WAIT_RISE: begin
                  if (rise) begin
                     state <= MEAS_HIGH;
                     pc    <= CNT_ONE;
                     hc    <= CNT_ONE;
                  end
               end
               MEAS_HIGH: begin
                  if (pc_sat) begin
                     state    <= WAIT_RISE;
                     pc       <= '0;
                     hc       <= '0;
                     overflow <= 1'b1;
                  end else if (fall) begin
                     state <= MEAS_LOW;
                     pc    <= pc + CNT_ONE;
                  end else begin
                     pc <= pc + CNT_ONE;
                     hc <= hc + CNT_ONE;
                  end
               end
               MEAS_LOW: begin
                  if (pc_sat) begin
                     state    <= WAIT_RISE;
                     pc       <= '0;
                     hc       <= '0;
                     overflow <= 1'b1;
                  end else if (rise) begin
                     state <= MEAS_HIGH;
                     pc    <= CNT_ONE;
                     hc    <= CNT_ONE;
                  end else begin
                     pc <= pc + CNT_ONE;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         // New result may replace the held one only when it is being consumed.
         if (done) begin
            if (!meas_valid || meas_ready) begin
               period_cnt <= pc;
               high_cnt   <= hc;
               meas_valid <= 1'b1;
            end else begin
               dropped <= 1'b1;
            end
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_meter.sv
// Self-checking bench for pwm_meter: directed scenarios plus randomised PWM,
// backpressure, clear and enable, checked against a waveform-level model.
module tb_pwm_meter;

   localparam int unsigned W     = 4;
   localparam int unsigned S     = 2;
   localparam int          MAXC  = 16384;
   localparam int          LIMIT = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         clear;
   logic         pwm_in;
   logic         meas_ready;
   logic [W-1:0] high_cnt;
   logic [W-1:0] period_cnt;
   logic         meas_valid;
   logic         overflow;
   logic         dropped;

   pwm_meter #(.CNT_W(W), .SYNC_STAGES(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clear      (clear),
      .pwm_in     (pwm_in),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .meas_valid (meas_valid),
      .meas_ready (meas_ready),
      .overflow   (overflow),
      .dropped    (dropped)
   );

   always #5 clk = ~clk;

   int n_checks   = 0;
   int n_pass     = 0;
   int cyc        = 0;
   int valid_seen = 0;
   bit rnd        = 1'b0;
   bit wave [MAXC];

   // Reference model state: rise/fall positions in the sampled waveform.
   bit active, have_rise;
   int last_rise, last_fall;
   bit exp_valid, exp_ovf, exp_drop;
   int exp_high, exp_period;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
   endtask

   task automatic check_outputs();
      check("meas_valid", 32'(meas_valid), 32'(exp_valid));
      check("high_cnt", 32'(high_cnt), 32'(exp_high));
      check("period_cnt", 32'(period_cnt), 32'(exp_period));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      check("dropped", 32'(dropped), 32'(exp_drop));
   endtask

   task automatic model_reset();
      active     = 1'b0;
      have_rise  = 1'b0;
      exp_valid  = 1'b0;
      exp_ovf    = 1'b0;
      exp_drop   = 1'b0;
      exp_high   = 0;
      exp_period = 0;
   endtask

   // One clock edge as seen by the meter: s_pwm at this edge is the sample
   // taken S edges earlier.
   task automatic model_edge(input bit e, input bit clr, input bit rdy);
      int k;
      bit r, f, fin;
      int mh, mp;
      k   = cyc - S;
      r   = (k >= 1) && wave[k] && !wave[k-1];
      f   = (k >= 1) && !wave[k] && wave[k-1];
      fin = 1'b0;
      mh  = 0;
      mp  = 0;
      if (clr) begin
         exp_ovf  = 1'b0;
         exp_drop = 1'b0;
      end
      if (!e) begin
         active    = 1'b0;
         have_rise = 1'b0;
      end else if (!active) begin
         active = 1'b1;
      end else if (have_rise && (k - last_rise) == LIMIT) begin
         exp_ovf   = 1'b1;
         have_rise = 1'b0;
      end else if (r) begin
         if (have_rise) begin
            fin = 1'b1;
            mh  = last_fall - last_rise;
            mp  = k - last_rise;
         end
         have_rise = 1'b1;
         last_rise = k;
      end else if (f && have_rise) begin
         last_fall = k;
      end
      if (fin) begin
         if (!exp_valid || rdy) begin
            exp_valid  = 1'b1;
            exp_high   = mh;
            exp_period = mp;
         end else begin
            exp_drop = 1'b1;
         end
      end else if (exp_valid && rdy) begin
         exp_valid = 1'b0;
      end
   endtask

   task automatic tick(input logic p);
      bit e, c, r, rs;
      if (rnd) begin
         meas_ready = ($urandom_range(0, 3) != 0);
         clear      = ($urandom_range(0, 29) == 0);
      end
      pwm_in = p;
      e  = en;
      c  = clear;
      r  = meas_ready;
      rs = rst;
      wave[cyc] = rs ? 1'b0 : p;
      @(posedge clk);
      if (rs) model_reset();
      else model_edge(e, c, r);
      cyc++;
      #1;
      check_outputs();
      if (meas_valid) valid_seen++;
      clear = 1'b0;
   endtask

   task automatic run_pwm(input int h, input int l);
      repeat (h) tick(1'b1);
      repeat (l) tick(1'b0);
   endtask

   // Asynchronous reset: the synchroniser and edge detector lose their contents.
   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = cyc - S - 1; i < cyc; i++)
         if (i >= 0) wave[i] = 1'b0;
      model_reset();
      #1;
      check_outputs();
      repeat (cycles) tick(1'b0);
      rst = 1'b0;
   endtask

   initial begin
      en         = 1'b0;
      clear      = 1'b0;
      pwm_in     = 1'b0;
      meas_ready = 1'b0;
      model_reset();
      do_reset(3);

      // Scenario 1: 3 high / 7 low, always ready
      en         = 1'b1;
      meas_ready = 1'b1;
      valid_seen = 0;
      repeat (5) run_pwm(3, 7);
      check("s1_pulses", 32'(valid_seen), 32'd4);
      check("s1_high", 32'(high_cnt), 32'd3);
      check("s1_period", 32'(period_cnt), 32'd10);

      // Scenario 2: backpressure across several periods
      meas_ready = 1'b0;
      repeat (3) run_pwm(3, 7);
      check("s2_held_valid", 32'(meas_valid), 32'd1);
      check("s2_dropped", 32'(dropped), 32'd1);
      check("s2_held_high", 32'(high_cnt), 32'd3);
      check("s2_held_period", 32'(period_cnt), 32'd10);
      meas_ready = 1'b1;
      tick(1'b1);
      check("s2_consumed", 32'(meas_valid), 32'd0);
      clear = 1'b1;
      tick(1'b1);
      check("s2_cleared", 32'(dropped), 32'd0);
      run_pwm(1, 7);

      // Period boundary: 14 is measurable, 15 saturates the counter
      repeat (3) run_pwm(2, 12);
      check("b14_period", 32'(period_cnt), 32'd14);
      check("b14_ovf", 32'(overflow), 32'd0);
      repeat (2) run_pwm(2, 13);
      check("b15_ovf", 32'(overflow), 32'd1);
      clear = 1'b1;
      tick(1'b0);
      check("b15_clear", 32'(overflow), 32'd0);

      // Scenario 3: stuck high
      repeat (20) tick(1'b1);
      check("s3_ovf", 32'(overflow), 32'd1);
      check("s3_valid", 32'(meas_valid), 32'd0);
      clear = 1'b1;
      repeat (5) tick(1'b0);

      // Scenario 4: enable dropped in the low phase, then 5/5
      repeat (2) run_pwm(5, 5);
      run_pwm(5, 4);
      en = 1'b0;
      repeat (3) tick(1'b0);
      en         = 1'b1;
      valid_seen = 0;
      repeat (4) run_pwm(5, 5);
      check("s4_pulses", 32'(valid_seen), 32'd3);
      check("s4_high", 32'(high_cnt), 32'd5);
      check("s4_period", 32'(period_cnt), 32'd10);

      // Scenario 5: reset in the high phase while a result is held
      meas_ready = 1'b0;
      repeat (2) run_pwm(5, 5);
      repeat (3) tick(1'b1);
      check("s5_pre_valid", 32'(meas_valid), 32'd1);
      do_reset(3);
      check("s5_rst_valid", 32'(meas_valid), 32'd0);
      check("s5_rst_period", 32'(period_cnt), 32'd0);
      meas_ready = 1'b1;
      repeat (4) run_pwm(4, 6);
      check("s5_high", 32'(high_cnt), 32'd4);
      check("s5_period", 32'(period_cnt), 32'd10);

      // Scenario 6: fastest measurable waveform
      repeat (11) run_pwm(1, 1);
      check("s6_high", 32'(high_cnt), 32'd1);
      check("s6_period", 32'(period_cnt), 32'd2);

      // Randomised waveform, backpressure, clear and enable
      rnd = 1'b1;
      for (int i = 0; i < 260 && cyc < MAXC - 64; i++) begin
         int h, l;
         h = $urandom_range(1, 9);
         l = $urandom_range(1, 9);
         if ($urandom_range(0, 9) == 0) l = $urandom_range(10, 16);
         if ($urandom_range(0, 19) == 0) h = $urandom_range(12, 17);
         en = ($urandom_range(0, 39) != 0);
         run_pwm(h, l);
      end
      rnd        = 1'b0;
      en         = 1'b1;
      meas_ready = 1'b1;
      repeat (6) tick(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
